// File: rtl/camera_scroll_controller_pkg.sv
// camera_scroll_controller_pkg: display geometry and scroll FSM encoding.
package camera_scroll_controller_pkg;
    localparam int WIDTH  = 96;
    localparam int HEIGHT = 64;
    localparam int PIXELS = WIDTH * HEIGHT;
    typedef enum logic [1:0] {IDLE, HOLD_L, HOLD_R} scroll_state_t;
endpackage

// File: rtl/camera_scroll_controller_scroll_step_fsm.sv
// scroll_step_fsm: switch-driven repeat stepping of the horizontal frame offset.
module scroll_step_fsm
    import camera_scroll_controller_pkg::*;
#(
    parameter int WORLD_W     = 192,
    parameter int STEP_FRAMES = 4,
    parameter int STEP_PX     = 1
) (
    input  logic       my_clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       switch_left,
    input  logic       switch_right,
    output logic [7:0] offset_x
);
    localparam logic [7:0] MAX_OFF = 8'(WORLD_W - WIDTH);
    localparam logic [3:0] RELOAD  = 4'(STEP_FRAMES - 1);
    scroll_state_t state, state_n, req_state;
    logic [3:0] cnt, cnt_n;
    logic [7:0] off_n, left_off, right_off;
    logic [8:0] sum_r;
    logic       step;
    assign req_state = (switch_left & ~switch_right) ? HOLD_L :
                       (switch_right & ~switch_left) ? HOLD_R : IDLE;
    assign sum_r     = {1'b0, offset_x} + 9'(STEP_PX);
    assign left_off  = offset_x > 8'(STEP_PX) ? offset_x - 8'(STEP_PX) : 8'd0;
    assign right_off = sum_r > {1'b0, MAX_OFF} ? MAX_OFF : sum_r[7:0];
    // A fresh or reversed request steps at once; a sustained one steps when the counter expires.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        off_n   = offset_x;
        step    = 1'b0;
        if (frame_tick) begin
            state_n = req_state;
            step    = (req_state != IDLE) && (req_state != state || cnt == 4'd0);
            cnt_n   = req_state == IDLE ? 4'd0 : step ? RELOAD : cnt - 4'd1;
            off_n   = !step ? offset_x : req_state == HOLD_L ? left_off : right_off;
        end
    end
    always_ff @(posedge my_clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            offset_x <= 8'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            offset_x <= off_n;
        end
    end
endmodule

// File: rtl/camera_scroll_controller.sv
// camera_scroll_controller: scrolls a 96x64 window across a wider world and maps raster
// indices to world coordinates through a 2-stage pipeline.
module camera_scroll_controller
    import camera_scroll_controller_pkg::*;
#(
    parameter int WORLD_W     = 192,
    parameter int STEP_FRAMES = 4,
    parameter int STEP_PX     = 1
) (
    input  logic        my_clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        switch_left,
    input  logic        switch_right,
    input  logic [12:0] pixel_index,
    output logic [7:0]  world_x,
    output logic [6:0]  world_y,
    output logic        coord_valid,
    output logic [7:0]  offset_x,
    output logic        at_left_edge,
    output logic        at_right_edge
);
    logic [6:0] x1, y1;
    logic       v1, in_range;
    scroll_step_fsm #(
        .WORLD_W(WORLD_W),
        .STEP_FRAMES(STEP_FRAMES),
        .STEP_PX(STEP_PX)
    ) u_fsm (
        .my_clock(my_clock),
        .reset(reset),
        .frame_tick(frame_tick),
        .switch_left(switch_left),
        .switch_right(switch_right),
        .offset_x(offset_x)
    );
    assign in_range      = pixel_index < 13'(PIXELS);
    assign at_left_edge  = offset_x == 8'd0;
    assign at_right_edge = offset_x == 8'(WORLD_W - WIDTH);
    always_ff @(posedge my_clock or posedge reset) begin
        if (reset) begin
            x1          <= 7'd0;
            y1          <= 7'd0;
            v1          <= 1'b0;
            world_x     <= 8'd0;
            world_y     <= 7'd0;
            coord_valid <= 1'b0;
        end else begin
            x1          <= in_range ? 7'(pixel_index % 13'(WIDTH)) : 7'd0;
            y1          <= in_range ? 7'(pixel_index / 13'(WIDTH)) : 7'd0;
            v1          <= in_range;
            world_x     <= v1 ? {1'b0, x1} + offset_x : 8'd0;
            world_y     <= v1 ? y1 : 7'd0;
            coord_valid <= v1;
        end
    end
endmodule

// File: tb/tb_camera_scroll_controller.sv
// tb_camera_scroll_controller: directed scenarios for scroll stepping and coordinate mapping.
module tb_camera_scroll_controller;
    logic        my_clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        switch_left = 1'b0;
    logic        switch_right = 1'b0;
    logic [12:0] pixel_index = 13'd0;
    logic [7:0]  world_x, offset_x;
    logic [6:0]  world_y;
    logic        coord_valid, at_left_edge, at_right_edge;
    int total = 0;
    int bad = 0;

    camera_scroll_controller dut (
        .my_clock(my_clock),
        .reset(reset),
        .frame_tick(frame_tick),
        .switch_left(switch_left),
        .switch_right(switch_right),
        .pixel_index(pixel_index),
        .world_x(world_x),
        .world_y(world_y),
        .coord_valid(coord_valid),
        .offset_x(offset_x),
        .at_left_edge(at_left_edge),
        .at_right_edge(at_right_edge)
    );

    always #5 my_clock = ~my_clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge my_clock);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        total += 6;
        if (offset_x !== 8'd0) begin bad++; $display("FAIL reset_offset got=%0d want=0", offset_x); end
        if (world_x !== 8'd0) begin bad++; $display("FAIL reset_world_x got=%0d want=0", world_x); end
        if (world_y !== 7'd0) begin bad++; $display("FAIL reset_world_y got=%0d want=0", world_y); end
        if (coord_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", coord_valid); end
        if (at_left_edge !== 1'b1) begin bad++; $display("FAIL reset_left_edge got=%b want=1", at_left_edge); end
        if (at_right_edge !== 1'b0) begin bad++; $display("FAIL reset_right_edge got=%b want=0", at_right_edge); end
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_coord();
        pixel_index = 13'd97;
        cyc(2);
        total += 4;
        if (world_x !== 8'd1) begin bad++; $display("FAIL coord97_x got=%0d want=1", world_x); end
        if (world_y !== 7'd1) begin bad++; $display("FAIL coord97_y got=%0d want=1", world_y); end
        if (coord_valid !== 1'b1) begin bad++; $display("FAIL coord97_valid got=%b want=1", coord_valid); end
        if (offset_x !== 8'd0) begin bad++; $display("FAIL coord97_offset got=%0d want=0", offset_x); end
        pixel_index = 13'd6143;
        cyc(1);
        total++;
        if (world_x !== 8'd1) begin bad++; $display("FAIL coord_latency_x got=%0d want=1", world_x); end
        cyc(1);
        total += 3;
        if (world_x !== 8'd95) begin bad++; $display("FAIL coord6143_x got=%0d want=95", world_x); end
        if (world_y !== 7'd63) begin bad++; $display("FAIL coord6143_y got=%0d want=63", world_y); end
        if (coord_valid !== 1'b1) begin bad++; $display("FAIL coord6143_valid got=%b want=1", coord_valid); end
    endtask

    task automatic test_invalid();
        pixel_index = 13'd6144;
        cyc(2);
        total += 3;
        if (coord_valid !== 1'b0) begin bad++; $display("FAIL inv_valid got=%b want=0", coord_valid); end
        if (world_x !== 8'd0) begin bad++; $display("FAIL inv_x got=%0d want=0", world_x); end
        if (world_y !== 7'd0) begin bad++; $display("FAIL inv_y got=%0d want=0", world_y); end
    endtask

    task automatic test_hold_right();
        switch_right = 1'b1;
        cyc(3);
        total++;
        if (offset_x !== 8'd0) begin bad++; $display("FAIL no_tick_offset got=%0d want=0", offset_x); end
        for (int k = 1; k <= 9; k++) begin
            frame();
            total++;
            if (offset_x !== 8'((k + 3) / 4)) begin
                bad++;
                $display("FAIL hold_right_tick%0d got=%0d want=%0d", k, offset_x, (k + 3) / 4);
            end
        end
    endtask

    task automatic test_both_and_reverse();
        switch_left = 1'b1;
        frame();
        total++;
        if (offset_x !== 8'd3) begin bad++; $display("FAIL both_offset got=%0d want=3", offset_x); end
        switch_left = 1'b0;
        frame();
        total++;
        if (offset_x !== 8'd4) begin bad++; $display("FAIL idle_to_right got=%0d want=4", offset_x); end
        switch_right = 1'b0;
        switch_left = 1'b1;
        frame();
        total++;
        if (offset_x !== 8'd3) begin bad++; $display("FAIL right_to_left got=%0d want=3", offset_x); end
    endtask

    task automatic test_right_edge();
        switch_left = 1'b0;
        frame();
        switch_right = 1'b1;
        repeat (365) frame();
        total++;
        if (offset_x !== 8'd95) begin bad++; $display("FAIL reach95 got=%0d want=95", offset_x); end
        switch_right = 1'b0;
        frame();
        switch_right = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            frame();
            total += 2;
            if (offset_x !== 8'd96) begin bad++; $display("FAIL clamp_tick%0d got=%0d want=96", k, offset_x); end
            if (at_right_edge !== 1'b1) begin bad++; $display("FAIL right_edge_tick%0d got=%b want=1", k, at_right_edge); end
        end
        pixel_index = 13'd95;
        cyc(2);
        total += 2;
        if (world_x !== 8'd191) begin bad++; $display("FAIL edge_world_x got=%0d want=191", world_x); end
        if (at_left_edge !== 1'b0) begin bad++; $display("FAIL edge_left_flag got=%b want=0", at_left_edge); end
    endtask

    task automatic test_async_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        switch_right = 1'b1;
        repeat (37) frame();
        pixel_index = 13'd97;
        cyc(2);
        total += 2;
        if (offset_x !== 8'd10) begin bad++; $display("FAIL pre_reset_offset got=%0d want=10", offset_x); end
        if (coord_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", coord_valid); end
        #2 reset = 1'b1;
        #1;
        total += 2;
        if (offset_x !== 8'd0) begin bad++; $display("FAIL async_offset got=%0d want=0", offset_x); end
        if (coord_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", coord_valid); end
        cyc(1);
        reset = 1'b0;
        frame();
        total++;
        if (offset_x !== 8'd1) begin bad++; $display("FAIL post_reset_step got=%0d want=1", offset_x); end
        switch_right = 1'b0;
        switch_left = 1'b1;
        repeat (6) frame();
        total += 2;
        if (offset_x !== 8'd0) begin bad++; $display("FAIL left_clamp got=%0d want=0", offset_x); end
        if (at_left_edge !== 1'b1) begin bad++; $display("FAIL left_edge got=%b want=1", at_left_edge); end
        switch_left = 1'b0;
    endtask

    initial begin
        test_reset();
        test_coord();
        test_invalid();
        test_hold_right();
        test_both_and_reverse();
        test_right_edge();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
